// File: rtl/axi_qspi_cmd_queue.sv
// axi_qspi_cmd_queue: register front-end that queues QSPI commands and their results.
// Defining QSPI_TIMEOUT_EN adds a watchdog that aborts a stalled transaction (qspi_abort port).
module axi_qspi_cmd_queue #(
    parameter int DATA_W  = 64,
    parameter int NBANKS  = 4,
    parameter int DEPTH   = 4,
    parameter int ERR_W   = 8,
    parameter int TMO_CYC = 1000
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          wr_en,
    input  logic [31:0]                   wr_indx,
    input  logic [31:0]                   wr_data,
    output logic [1:0]                    wr_resp,
    output logic                          wr_idle,
    input  logic                          rd_en,
    input  logic [31:0]                   rd_indx,
    output logic [31:0]                   rd_data,
    output logic [1:0]                    rd_resp,
    output logic                          rd_idle,
    output logic [8+NBANKS+32+DATA_W-1:0] qspi_req_out,
    output logic                          qspi_start,
    input  logic                          qspi_done,
    input  logic [DATA_W-1:0]             qspi_rdata,
    input  logic [ERR_W-1:0]              qspi_error
`ifdef QSPI_TIMEOUT_EN
    ,
    output logic                          qspi_abort
`endif
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [7:0]    DEPTH_C = 8'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [1:0]    OKAY = 2'd0, SLVERR = 2'd2, DECERR = 2'd3;
    localparam logic [31:0]   REG_CMD = 32'd0, REG_BANKMAP = 32'd1, REG_ADDR = 32'd2,
                              REG_WDATA_H = 32'd3, REG_WDATA_L = 32'd4, REG_START = 32'd5,
                              REG_STATUS = 32'd6, REG_RDATA_H = 32'd7, REG_RDATA_L = 32'd8,
                              REG_ERROR = 32'd9, REG_POP = 32'd10;

    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nxt;

    logic [7:0]        cmd_r;
    logic [NBANKS-1:0] bank_r;
    logic [31:0]       addr_r, wdata_h_r, wdata_l_r;
    logic [DATA_W-1:0] stage_wdata;

    logic [7:0]        cmd_mem  [DEPTH];
    logic [NBANKS-1:0] bank_mem [DEPTH];
    logic [31:0]       addr_mem [DEPTH];
    logic [DATA_W-1:0] wdat_mem [DEPTH];
    logic [DATA_W-1:0] rdat_mem [DEPTH];
    logic [ERR_W-1:0]  err_mem  [DEPTH];

    logic [AW-1:0] cmd_wp, cmd_rp, res_wp, res_rp;
    logic [7:0]    cmd_cnt, res_cnt, pend_cnt;
    logic          cmd_full, cmd_empty, res_empty;
    logic          start_push, res_pop, launch, done_evt, tmo_evt, tmo_hit, cmd_pop, res_push;
    logic [DATA_W-1:0] res_push_data;
    logic [ERR_W-1:0]  res_push_err;
    logic [1:0]    wr_resp_nxt, rd_resp_nxt;
    logic [31:0]   rd_data_nxt, head_hi, head_lo, head_err, status;

    assign wr_idle   = ~wr_en;
    assign rd_idle   = ~rd_en;
    assign cmd_full  = (cmd_cnt == DEPTH_C);
    assign cmd_empty = (cmd_cnt == 8'd0);
    assign res_empty = (res_cnt == 8'd0);
    // The in-flight command stays in the FIFO until done; STATUS reports only those still pending.
    assign pend_cnt  = cmd_cnt - {7'd0, state == WAIT};
    assign status    = {13'd0, res_empty, cmd_full, state == WAIT, res_cnt, pend_cnt};
    assign head_err  = res_empty ? 32'd0 : 32'(err_mem[res_rp]);
    assign qspi_req_out = {cmd_mem[cmd_rp], bank_mem[cmd_rp], addr_mem[cmd_rp], wdat_mem[cmd_rp]};

    if (DATA_W == 64) begin : g_w64
        assign stage_wdata = {wdata_h_r, wdata_l_r};
        assign head_hi     = res_empty ? 32'd0 : rdat_mem[res_rp][63:32];
        assign head_lo     = res_empty ? 32'd0 : rdat_mem[res_rp][31:0];
    end else begin : g_w32
        assign stage_wdata = wdata_l_r;
        assign head_hi     = 32'd0;
        assign head_lo     = res_empty ? 32'd0 : rdat_mem[res_rp];
    end

    always_comb begin
        wr_resp_nxt = OKAY;
        start_push  = 1'b0;
        res_pop     = 1'b0;
        if (wr_en) begin
            case (wr_indx)
                REG_CMD, REG_BANKMAP, REG_ADDR, REG_WDATA_H, REG_WDATA_L: wr_resp_nxt = OKAY;
                REG_START: if (wr_data[0]) begin
                    if (cmd_full) wr_resp_nxt = SLVERR;
                    else          start_push  = 1'b1;
                end
                REG_POP: begin
                    if (res_empty) wr_resp_nxt = SLVERR;
                    else           res_pop     = 1'b1;
                end
                REG_STATUS, REG_RDATA_H, REG_RDATA_L, REG_ERROR: wr_resp_nxt = SLVERR;
                default: wr_resp_nxt = DECERR;
            endcase
        end
    end

    always_comb begin
        rd_data_nxt = 32'd0;
        rd_resp_nxt = OKAY;
        case (rd_indx)
            REG_CMD:            rd_data_nxt = {24'd0, cmd_r};
            REG_BANKMAP:        rd_data_nxt = 32'(bank_r);
            REG_ADDR:           rd_data_nxt = addr_r;
            REG_WDATA_H:        rd_data_nxt = (DATA_W == 64) ? wdata_h_r : 32'd0;
            REG_WDATA_L:        rd_data_nxt = wdata_l_r;
            REG_START, REG_POP: rd_data_nxt = 32'd0;
            REG_STATUS:         rd_data_nxt = status;
            REG_RDATA_H:        rd_data_nxt = head_hi;
            REG_RDATA_L:        rd_data_nxt = head_lo;
            REG_ERROR:          rd_data_nxt = head_err;
            default:            rd_resp_nxt = DECERR;
        endcase
    end

    // Dispatch only when a result slot is guaranteed for the outcome.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        done_evt  = 1'b0;
        tmo_evt   = 1'b0;
        case (state)
            IDLE: if (!cmd_empty && (res_cnt < DEPTH_C)) begin
                state_nxt = WAIT;
                launch    = 1'b1;
            end
            WAIT: if (qspi_done) begin
                done_evt  = 1'b1;
                state_nxt = IDLE;
            end else if (tmo_hit) begin
                tmo_evt   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_pop       = done_evt | tmo_evt;
    assign res_push      = cmd_pop;
    assign res_push_data = done_evt ? qspi_rdata : '0;
    assign res_push_err  = done_evt ? qspi_error : '1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            qspi_start <= 1'b0;
            cmd_wp     <= '0;
            cmd_rp     <= '0;
            res_wp     <= '0;
            res_rp     <= '0;
            cmd_cnt    <= 8'd0;
            res_cnt    <= 8'd0;
            wr_resp    <= OKAY;
            rd_resp    <= OKAY;
            rd_data    <= 32'd0;
            cmd_r      <= 8'd0;
            bank_r     <= '0;
            addr_r     <= 32'd0;
            wdata_h_r  <= 32'd0;
            wdata_l_r  <= 32'd0;
        end else begin
            state      <= state_nxt;
            qspi_start <= launch;
            if (start_push) cmd_wp <= cmd_wp + PTR_ONE;
            if (cmd_pop)    cmd_rp <= cmd_rp + PTR_ONE;
            if (res_push)   res_wp <= res_wp + PTR_ONE;
            if (res_pop)    res_rp <= res_rp + PTR_ONE;
            cmd_cnt <= cmd_cnt + {7'd0, start_push} - {7'd0, cmd_pop};
            res_cnt <= res_cnt + {7'd0, res_push} - {7'd0, res_pop};
            if (wr_en) begin
                wr_resp <= wr_resp_nxt;
                case (wr_indx)
                    REG_CMD:     cmd_r     <= wr_data[7:0];
                    REG_BANKMAP: bank_r    <= wr_data[NBANKS-1:0];
                    REG_ADDR:    addr_r    <= wr_data;
                    REG_WDATA_H: if (DATA_W == 64) wdata_h_r <= wr_data;
                    REG_WDATA_L: wdata_l_r <= wr_data;
                    default: ;
                endcase
            end
            if (rd_en) begin
                rd_data <= rd_data_nxt;
                rd_resp <= rd_resp_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_push) begin
            cmd_mem[cmd_wp]  <= cmd_r;
            bank_mem[cmd_wp] <= bank_r;
            addr_mem[cmd_wp] <= addr_r;
            wdat_mem[cmd_wp] <= stage_wdata;
        end
        if (res_push) begin
            rdat_mem[res_wp] <= res_push_data;
            err_mem[res_wp]  <= res_push_err;
        end
    end

`ifdef QSPI_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    // Counter is 0 in the first WAIT cycle, so the abort lands TMO_CYC cycles after qspi_start.
    assign tmo_hit = (tmo_cnt == TW'(TMO_CYC - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tmo_cnt    <= '0;
            qspi_abort <= 1'b0;
        end else begin
            qspi_abort <= tmo_evt;
            if (state != WAIT) tmo_cnt <= '0;
            else               tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    localparam int unused_tmo_cyc = TMO_CYC;
    assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_axi_qspi_cmd_queue.sv
// Directed bench for axi_qspi_cmd_queue: register table plus hand-written queue/dispatch sequences.
// The watchdog sequence runs only when QSPI_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_axi_qspi_cmd_queue;
    localparam int DATA_W  = 64;
    localparam int NBANKS  = 4;
    localparam int DEPTH   = 4;
    localparam int ERR_W   = 8;
    localparam int TMO_CYC = 100;
    localparam int REQ_W   = 8 + NBANKS + 32 + DATA_W;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0]       wr_indx = '0, wr_data = '0, rd_indx = '0;
    logic [1:0]        wr_resp, rd_resp;
    logic              wr_idle, rd_idle;
    logic [31:0]       rd_data;
    logic [REQ_W-1:0]  qspi_req_out;
    logic              qspi_start;
    logic              qspi_done = 1'b0;
    logic [DATA_W-1:0] qspi_rdata = '0;
    logic [ERR_W-1:0]  qspi_error = '0;
`ifdef QSPI_TIMEOUT_EN
    logic              qspi_abort;
`endif

    axi_qspi_cmd_queue #(
        .DATA_W(DATA_W), .NBANKS(NBANKS), .DEPTH(DEPTH), .ERR_W(ERR_W), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .resetn(resetn),
        .wr_en(wr_en), .wr_indx(wr_indx), .wr_data(wr_data), .wr_resp(wr_resp), .wr_idle(wr_idle),
        .rd_en(rd_en), .rd_indx(rd_indx), .rd_data(rd_data), .rd_resp(rd_resp), .rd_idle(rd_idle),
        .qspi_req_out(qspi_req_out), .qspi_start(qspi_start), .qspi_done(qspi_done),
        .qspi_rdata(qspi_rdata), .qspi_error(qspi_error)
`ifdef QSPI_TIMEOUT_EN
        , .qspi_abort(qspi_abort)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_start = 0;

    // Counted on posedge so the initial block, which samples on negedge, never races it.
    always @(posedge clk) if (qspi_start) n_start++;

    typedef struct {
        bit          is_wr;
        logic [31:0] idx;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rdat;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [31:0] idx, input logic [31:0] data, output logic [1:0] resp);
        @(negedge clk);
        wr_en = 1'b1; wr_indx = idx; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        resp = wr_resp;
    endtask

    task automatic rd_reg(input logic [31:0] idx, output logic [31:0] data, output logic [1:0] resp);
        @(negedge clk);
        rd_en = 1'b1; rd_indx = idx;
        @(negedge clk);
        rd_en = 1'b0;
        data = rd_data;
        resp = rd_resp;
    endtask

    task automatic engine_done(input logic [63:0] d, input logic [7:0] e);
        @(negedge clk);
        qspi_done = 1'b1; qspi_rdata = d; qspi_error = e;
        @(negedge clk);
        qspi_done = 1'b0; qspi_rdata = '0; qspi_error = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; qspi_done = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_start(input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max && cyc < 0; i++) begin
            @(negedge clk);
            if (qspi_start) cyc = i;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t        vt[$];
        logic [1:0]  resp;
        logic [31:0] data;
        int          cyc, base;
        logic [REQ_W-1:0] exp_req;

        vt.push_back(vec_t'{0, 32'd6,  32'h0,        2'd0, 32'h0004_0000});
        vt.push_back(vec_t'{0, 32'd0,  32'h0,        2'd0, 32'h0});
        vt.push_back(vec_t'{1, 32'd0,  32'h0000_016B, 2'd0, 32'h0});
        vt.push_back(vec_t'{0, 32'd0,  32'h0,        2'd0, 32'h0000_006B});
        vt.push_back(vec_t'{1, 32'd1,  32'h0000_00FF, 2'd0, 32'h0});
        vt.push_back(vec_t'{0, 32'd1,  32'h0,        2'd0, 32'h0000_000F});
        vt.push_back(vec_t'{1, 32'd1,  32'h0000_0005, 2'd0, 32'h0});
        vt.push_back(vec_t'{0, 32'd1,  32'h0,        2'd0, 32'h0000_0005});
        vt.push_back(vec_t'{1, 32'd2,  32'h0000_1000, 2'd0, 32'h0});
        vt.push_back(vec_t'{0, 32'd2,  32'h0,        2'd0, 32'h0000_1000});
        vt.push_back(vec_t'{1, 32'd3,  32'hA5A5_A5A5, 2'd0, 32'h0});
        vt.push_back(vec_t'{0, 32'd3,  32'h0,        2'd0, 32'hA5A5_A5A5});
        vt.push_back(vec_t'{1, 32'd4,  32'h5A5A_5A5A, 2'd0, 32'h0});
        vt.push_back(vec_t'{0, 32'd4,  32'h0,        2'd0, 32'h5A5A_5A5A});
        vt.push_back(vec_t'{0, 32'd5,  32'h0,        2'd0, 32'h0});
        vt.push_back(vec_t'{0, 32'd7,  32'h0,        2'd0, 32'h0});
        vt.push_back(vec_t'{0, 32'd8,  32'h0,        2'd0, 32'h0});
        vt.push_back(vec_t'{0, 32'd9,  32'h0,        2'd0, 32'h0});
        vt.push_back(vec_t'{1, 32'd10, 32'h1,        2'd2, 32'h0});
        vt.push_back(vec_t'{0, 32'd15, 32'h0,        2'd3, 32'h0});
        vt.push_back(vec_t'{1, 32'd11, 32'h1,        2'd3, 32'h0});
        vt.push_back(vec_t'{1, 32'd5,  32'h0,        2'd0, 32'h0});
        vt.push_back(vec_t'{0, 32'd6,  32'h0,        2'd0, 32'h0004_0000});

        repeat (3) @(negedge clk);
        check("reset_wr_resp", wr_resp, 2'd0);
        check("reset_rd_resp", rd_resp, 2'd0);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_qspi_start", qspi_start, 1'b0);
        check("reset_rd_idle", rd_idle, 1'b1);
        resetn = 1'b1;

        foreach (vt[i]) begin
            if (vt[i].is_wr) begin
                wr_reg(vt[i].idx, vt[i].data, resp);
                check($sformatf("vec%0d_wr_resp", i), resp, vt[i].resp);
            end else begin
                rd_reg(vt[i].idx, data, resp);
                check($sformatf("vec%0d_rd_resp", i), resp, vt[i].resp);
                check($sformatf("vec%0d_rd_data", i), data, vt[i].rdat);
            end
        end

        // Single transaction: latency, request contents, hold, result readback.
        wr_reg(32'd5, 32'h1, resp);
        check("start_resp", resp, 2'd0);
        check("start_not_early", qspi_start, 1'b0);
        @(negedge clk);
        check("start_latency", qspi_start, 1'b1);
        exp_req = {8'h6B, 4'h5, 32'h0000_1000, 64'hA5A5_A5A5_5A5A_5A5A};
        check("req_fields", qspi_req_out, exp_req);
        @(negedge clk);
        check("start_pulse", qspi_start, 1'b0);
        rd_reg(32'd6, data, resp);
        check("status_wait", data, 32'h0005_0000);
        wr_reg(32'd0, 32'h03, resp);
        repeat (3) @(negedge clk);
        check("req_hold", qspi_req_out, exp_req);
        engine_done(64'h1122_3344_5566_7788, 8'h00);
        rd_reg(32'd7, data, resp);
        check("rdata_h", data, 32'h1122_3344);
        rd_reg(32'd8, data, resp);
        check("rdata_l", data, 32'h5566_7788);
        rd_reg(32'd9, data, resp);
        check("error_zero", data, 32'h0);
        rd_reg(32'd6, data, resp);
        check("status_one_result", data, 32'h0000_0100);
        wr_reg(32'd10, 32'h0, resp);
        check("pop_resp", resp, 2'd0);
        rd_reg(32'd6, data, resp);
        check("status_after_pop", data, 32'h0004_0000);

        // Fill the command FIFO with the engine stalled.
        base = n_start;
        for (int i = 0; i < 5; i++) begin
            wr_reg(32'd5, 32'h1, resp);
            check($sformatf("fill_start%0d_resp", i), resp, (i < 4) ? 2'd0 : 2'd2);
        end
        rd_reg(32'd6, data, resp);
        check("status_cmd_full", data, 32'h0007_0003);

        // Complete all four, leaving results unpopped, then show dispatch blocks on result space.
        for (int i = 0; i < 4; i++) begin
            engine_done(64'h100 + 64'(i), 8'h00);
            repeat (2) @(negedge clk);
        end
        rd_reg(32'd6, data, resp);
        check("status_res_full", data, 32'h0000_0400);
        check("starts_for_four", n_start - base, 4);
        wr_reg(32'd5, 32'h1, resp);
        check("fifth_start_resp", resp, 2'd0);
        repeat (5) @(negedge clk);
        check("blocked_no_start", n_start - base, 4);
        rd_reg(32'd6, data, resp);
        check("status_blocked", data, 32'h0000_0401);
        wr_reg(32'd10, 32'h0, resp);
        wait_start(2, cyc);
        check("pop_unblocks_start", (cyc >= 1 && cyc <= 2), 1'b1);
        rd_reg(32'd8, data, resp);
        check("fifo_order_head1", data, 32'h0000_0101);
        engine_done(64'h0000_0000_0000_BEEF, 8'h5A);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) wr_reg(32'd10, 32'h0, resp);
        rd_reg(32'd8, data, resp);
        check("fifo_wrap_rdata", data, 32'h0000_BEEF);
        rd_reg(32'd9, data, resp);
        check("fifo_wrap_error", data, 32'h0000_005A);

        // Simultaneous START push with done-pop, then POP with result push.
        do_reset();
        wr_reg(32'd5, 32'h1, resp);
        wait_start(3, cyc);
        check("sim_first_start", cyc > 0, 1'b1);
        @(negedge clk);
        wr_en = 1'b1; wr_indx = 32'd5; wr_data = 32'h1;
        qspi_done = 1'b1; qspi_rdata = 64'hAA; qspi_error = 8'h00;
        @(negedge clk);
        wr_en = 1'b0; qspi_done = 1'b0; qspi_rdata = '0;
        check("sim_push_resp", wr_resp, 2'd0);
        wait_start(3, cyc);
        check("sim_second_start", cyc > 0, 1'b1);
        rd_reg(32'd6, data, resp);
        check("sim_status_a", data, 32'h0001_0100);
        @(negedge clk);
        wr_en = 1'b1; wr_indx = 32'd10; wr_data = 32'h0;
        qspi_done = 1'b1; qspi_rdata = 64'hBB;
        @(negedge clk);
        wr_en = 1'b0; qspi_done = 1'b0; qspi_rdata = '0;
        check("sim_pop_resp", wr_resp, 2'd0);
        rd_reg(32'd6, data, resp);
        check("sim_status_b", data, 32'h0000_0100);
        rd_reg(32'd8, data, resp);
        check("sim_rdata", data, 32'h0000_00BB);

        // Reset in WAIT, then a late done must be ignored.
        do_reset();
        wr_reg(32'd5, 32'h1, resp);
        wait_start(3, cyc);
        check("rst_mid_start", cyc > 0, 1'b1);
        do_reset();
        rd_reg(32'd6, data, resp);
        check("rst_mid_status", data, 32'h0004_0000);
        base = n_start;
        engine_done(64'hDEAD, 8'h11);
        repeat (3) @(negedge clk);
        rd_reg(32'd6, data, resp);
        check("late_done_ignored", data, 32'h0004_0000);
        check("late_done_no_start", n_start - base, 0);

`ifdef QSPI_TIMEOUT_EN
        do_reset();
        wr_reg(32'd5, 32'h1, resp);
        wait_start(3, cyc);
        check("tmo_start", cyc > 0, 1'b1);
        cyc = -1;
        for (int k = 1; k <= 200 && cyc < 0; k++) begin
            @(negedge clk);
            if (qspi_abort) cyc = k;
        end
        check("tmo_abort_delay", cyc, TMO_CYC);
        @(negedge clk);
        check("tmo_abort_pulse", qspi_abort, 1'b0);
        rd_reg(32'd9, data, resp);
        check("tmo_error", data, 32'h0000_00FF);
        rd_reg(32'd8, data, resp);
        check("tmo_rdata", data, 32'h0);
        rd_reg(32'd6, data, resp);
        check("tmo_status", data, 32'h0000_0100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
